// File: rtl/uvmt_cv32e40x_sl_trigger_mem_scheduler.sv
// Collects the data accesses of the in-flight instruction, snapshots them on retire and scans
// one access per cycle through a shared load/store trigger comparator bank.
module uvmt_cv32e40x_sl_trigger_mem_scheduler #(
    parameter int NUM_TRIGGERS   = 4,
    parameter int MAX_MEM_ACCESS = 13,
    parameter int IDX_W          = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mem_valid_i,
    input  logic [31:0]               mem_addr_i,
    input  logic                      mem_we_i,
    input  logic                      instr_valid_i,
    input  logic                      instr_dbg_i,
    input  logic                      exec_exc_match_i,
    input  logic [NUM_TRIGGERS-1:0]   mode_ok_i,
    input  logic [NUM_TRIGGERS*32-1:0] tdata1_i,
    input  logic [NUM_TRIGGERS*32-1:0] tdata2_i,
    output logic                      busy_o,
    output logic                      result_valid_o,
    output logic [NUM_TRIGGERS-1:0]   match_o,
    output logic [IDX_W-1:0]          match_idx_o,
    output logic                      overflow_o,
    output logic                      overrun_o
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    state_e                    state_q, state_d;

    logic [31:0]               buf_addr_q [MAX_MEM_ACCESS];
    logic [MAX_MEM_ACCESS-1:0] buf_we_q;
    logic [IDX_W-1:0]          cnt_q, cnt_d;

    logic [31:0]               scan_addr_q [MAX_MEM_ACCESS];
    logic [MAX_MEM_ACCESS-1:0] scan_we_q;
    logic [IDX_W-1:0]          scan_n_q;
    logic [IDX_W-1:0]          scan_k_q, scan_k_d;

    logic                      result_valid_q, result_valid_d;
    logic [NUM_TRIGGERS-1:0]   match_q, match_d;
    logic [IDX_W-1:0]          match_idx_q, match_idx_d;
    logic                      overflow_q, overflow_d;
    logic                      overrun_q, overrun_d;

    logic                      acc_full;
    logic                      acc_take;
    logic [IDX_W-1:0]          retire_n;
    logic                      retire_scan;
    logic [NUM_TRIGGERS-1:0]   hit_mask;

    function automatic logic trig_hit(
        input logic [31:0] td1,
        input logic [31:0] td2,
        input logic [31:0] addr,
        input logic        we,
        input logic        ok
    );
        logic addr_hit;
        logic type_hit;
        case (td1[10:7])
            4'd0:    addr_hit = (addr == td2);
            4'd2:    addr_hit = (addr >= td2);
            4'd3:    addr_hit = (addr < td2);
            default: addr_hit = 1'b0;
        endcase
        type_hit = we ? td1[1] : td1[0];
        return ok && addr_hit && type_hit;
    endfunction

    // An access arriving together with the retire strobe belongs to the retiring instruction.
    assign acc_full    = (cnt_q == IDX_W'(MAX_MEM_ACCESS));
    assign acc_take    = mem_valid_i && !acc_full;
    assign retire_n    = cnt_q + IDX_W'(acc_take);
    assign retire_scan = instr_valid_i && (retire_n != '0) && !instr_dbg_i && !exec_exc_match_i;

    always_comb begin
        hit_mask = '0;
        for (int t = 0; t < NUM_TRIGGERS; t++) begin
            hit_mask[t] = trig_hit(tdata1_i[t*32 +: 32], tdata2_i[t*32 +: 32],
                                   scan_addr_q[scan_k_q], scan_we_q[scan_k_q], mode_ok_i[t]);
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q | (mem_valid_i & acc_full);
        if (instr_valid_i) begin
            cnt_d = '0;
        end else if (acc_take) begin
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    // A retire always wins: a running scan is dropped without a result and the new snapshot restarts.
    always_comb begin
        state_d        = state_q;
        scan_k_d       = scan_k_q;
        result_valid_d = 1'b0;
        match_d        = '0;
        match_idx_d    = '0;
        overrun_d      = overrun_q;
        if (instr_valid_i) begin
            if (state_q == SCAN) begin
                overrun_d = 1'b1;
            end
            scan_k_d = '0;
            if (retire_scan) begin
                state_d = SCAN;
            end else begin
                state_d        = IDLE;
                result_valid_d = 1'b1;
            end
        end else if (state_q == SCAN) begin
            if (hit_mask != '0) begin
                state_d        = IDLE;
                result_valid_d = 1'b1;
                match_d        = hit_mask;
                match_idx_d    = scan_k_q;
            end else if (scan_k_q == scan_n_q - IDX_W'(1)) begin
                state_d        = IDLE;
                result_valid_d = 1'b1;
            end else begin
                scan_k_d = scan_k_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            scan_k_q       <= '0;
            result_valid_q <= 1'b0;
            match_q        <= '0;
            match_idx_q    <= '0;
            overflow_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            scan_k_q       <= scan_k_d;
            result_valid_q <= result_valid_d;
            match_q        <= match_d;
            match_idx_q    <= match_idx_d;
            overflow_q     <= overflow_d;
            overrun_q      <= overrun_d;
        end
    end

    // Access payload storage needs no reset; cnt_q and scan_n_q decide which slots are live.
    always_ff @(posedge clk_i) begin
        if (acc_take) begin
            buf_addr_q[cnt_q] <= mem_addr_i;
            buf_we_q[cnt_q]   <= mem_we_i;
        end
        if (instr_valid_i) begin
            scan_n_q <= retire_n;
            for (int i = 0; i < MAX_MEM_ACCESS; i++) begin
                if (acc_take && (cnt_q == IDX_W'(i))) begin
                    scan_addr_q[i] <= mem_addr_i;
                    scan_we_q[i]   <= mem_we_i;
                end else begin
                    scan_addr_q[i] <= buf_addr_q[i];
                    scan_we_q[i]   <= buf_we_q[i];
                end
            end
        end
    end

    assign busy_o         = (state_q == SCAN);
    assign result_valid_o = result_valid_q;
    assign match_o        = match_q;
    assign match_idx_o    = match_idx_q;
    assign overflow_o     = overflow_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_uvmt_cv32e40x_sl_trigger_mem_scheduler.sv
// Directed bench for the load/store trigger scheduler: a queue-based model predicts every
// result pulse, busy window and sticky flag, and directed tests pin latencies with literals.
module tb_uvmt_cv32e40x_sl_trigger_mem_scheduler;

    localparam int NT  = 4;
    localparam int MAX = 13;
    localparam int IW  = 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           mem_valid_i;
    logic [31:0]    mem_addr_i;
    logic           mem_we_i;
    logic           instr_valid_i;
    logic           instr_dbg_i;
    logic           exec_exc_match_i;
    logic [NT-1:0]  mode_ok_i;
    logic [NT*32-1:0] tdata1_i;
    logic [NT*32-1:0] tdata2_i;
    logic           busy_o;
    logic           result_valid_o;
    logic [NT-1:0]  match_o;
    logic [IW-1:0]  match_idx_o;
    logic           overflow_o;
    logic           overrun_o;

    int checks = 0;
    int errors = 0;

    uvmt_cv32e40x_sl_trigger_mem_scheduler #(
        .NUM_TRIGGERS  (NT),
        .MAX_MEM_ACCESS(MAX),
        .IDX_W         (IW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .mem_valid_i     (mem_valid_i),
        .mem_addr_i      (mem_addr_i),
        .mem_we_i        (mem_we_i),
        .instr_valid_i   (instr_valid_i),
        .instr_dbg_i     (instr_dbg_i),
        .exec_exc_match_i(exec_exc_match_i),
        .mode_ok_i       (mode_ok_i),
        .tdata1_i        (tdata1_i),
        .tdata2_i        (tdata2_i),
        .busy_o          (busy_o),
        .result_valid_o  (result_valid_o),
        .match_o         (match_o),
        .match_idx_o     (match_idx_o),
        .overflow_o      (overflow_o),
        .overrun_o       (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: accesses of the in-flight instruction and the one outstanding result
    logic [31:0] accAddr[$];
    bit          accWe[$];
    int          cyc = 0;
    bit          pendValid = 0;
    bit          pendScan = 0;
    int          pendCyc = 0;
    logic [NT-1:0] pendMatch = '0;
    int          pendIdx = 0;
    bit          expOvf = 0;
    bit          expOvr = 0;

    function automatic logic [NT-1:0] modelMask(input logic [31:0] a, input bit we);
        logic [NT-1:0] m;
        m = '0;
        for (int t = 0; t < NT; t++) begin
            logic [31:0] d1, d2;
            int code;
            bit inRange, typeOk;
            d1 = tdata1_i[t*32 +: 32];
            d2 = tdata2_i[t*32 +: 32];
            code = int'(d1[10:7]);
            inRange = (code == 0 && a == d2) || (code == 2 && a >= d2) || (code == 3 && a < d2);
            typeOk = we ? d1[1] : d1[0];
            m[t] = mode_ok_i[t] && inRange && typeOk;
        end
        return m;
    endfunction

    // The model consumes the inputs of cycle cyc at its closing edge and schedules the result
    always @(posedge clk_i) begin
        if (rst_i) begin
            accAddr.delete();
            accWe.delete();
            pendValid = 0;
            expOvf = 0;
            expOvr = 0;
        end else begin
            if (mem_valid_i) begin
                if (accAddr.size() < MAX) begin
                    accAddr.push_back(mem_addr_i);
                    accWe.push_back(mem_we_i);
                end else begin
                    expOvf = 1;
                end
            end
            if (instr_valid_i) begin
                int n;
                bit found;
                if (pendValid && pendScan && cyc < pendCyc) expOvr = 1;
                n = accAddr.size();
                pendValid = 1;
                pendMatch = '0;
                pendIdx = 0;
                if (n > 0 && !instr_dbg_i && !exec_exc_match_i) begin
                    pendScan = 1;
                    pendCyc = cyc + n + 1;
                    found = 0;
                    for (int k = 0; k < n; k++) begin
                        if (!found && modelMask(accAddr[k], accWe[k]) != '0) begin
                            found = 1;
                            pendMatch = modelMask(accAddr[k], accWe[k]);
                            pendIdx = k;
                            pendCyc = cyc + 2 + k;
                        end
                    end
                end else begin
                    pendScan = 0;
                    pendCyc = cyc + 1;
                end
                accAddr.delete();
                accWe.delete();
            end
        end
        cyc = cyc + 1;
    end

    // Every cycle after the first reset edge, all outputs are held against the model
    always @(negedge clk_i) begin
        if (cyc >= 1) begin
            bit expValid, expBusy;
            expValid = pendValid && (cyc == pendCyc);
            expBusy  = pendValid && pendScan && (cyc < pendCyc);
            checkOutput("result_valid", result_valid_o, expValid);
            checkOutput("busy", busy_o, expBusy);
            checkOutput("overflow", overflow_o, expOvf);
            checkOutput("overrun", overrun_o, expOvr);
            checkOutput("match", match_o, expValid ? pendMatch : '0);
            checkOutput("match_idx", match_idx_o, expValid ? pendIdx : 0);
            if (expValid) pendValid = 0;
        end
    end

    task automatic applyStimulus(input bit mv, input logic [31:0] a, input bit we, input bit iv);
        mem_valid_i   = mv;
        mem_addr_i    = a;
        mem_we_i      = we;
        instr_valid_i = iv;
        @(posedge clk_i);
        #2;
        mem_valid_i   = 1'b0;
        mem_addr_i    = '0;
        mem_we_i      = 1'b0;
        instr_valid_i = 1'b0;
    endtask

    task automatic setTrig(input int t, input logic [31:0] d1, input logic [31:0] d2);
        tdata1_i[t*32 +: 32] = d1;
        tdata2_i[t*32 +: 32] = d2;
    endtask

    task automatic waitResult(input string name, input logic [NT-1:0] expMatch,
                              input int expIdx, input int expLat);
        int lat;
        bit got;
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(negedge clk_i);
            lat++;
            if (result_valid_o) got = 1;
        end
        checkOutput({name, "_latency"}, lat, expLat);
        if (got) begin
            checkOutput({name, "_match"}, match_o, expMatch);
            checkOutput({name, "_idx"}, match_idx_o, expIdx);
        end
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        mem_valid_i = 1'b0;
        mem_addr_i = '0;
        mem_we_i = 1'b0;
        instr_valid_i = 1'b0;
        instr_dbg_i = 1'b0;
        exec_exc_match_i = 1'b0;
        mode_ok_i = '1;
        tdata1_i = '0;
        tdata2_i = '0;
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        checkOutput("reset_valid", result_valid_o, 0);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_flags", {overflow_o, overrun_o}, 0);

        $display("[TB] load hits trigger0 equality");
        setTrig(0, 32'h2000_0001, 32'h0000_1000);
        applyStimulus(1, 32'h1000, 0, 0);
        applyStimulus(0, 0, 0, 1);
        waitResult("t1", 4'b0001, 0, 2);

        $display("[TB] store-only trigger1, six accesses");
        setTrig(1, 32'h2000_0002, 32'h0000_2008);
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'h2000 + 4 * i, 0, 0);
        applyStimulus(1, 32'h2008, 1, 1);
        waitResult("t2", 4'b0010, 5, 7);

        $display("[TB] retire with execute match or debug skips the scan");
        exec_exc_match_i = 1'b1;
        applyStimulus(1, 32'h1000, 0, 0);
        applyStimulus(0, 0, 0, 1);
        exec_exc_match_i = 1'b0;
        waitResult("t3exc", 4'b0000, 0, 1);
        instr_dbg_i = 1'b1;
        applyStimulus(1, 32'h1000, 0, 1);
        instr_dbg_i = 1'b0;
        waitResult("t3dbg", 4'b0000, 0, 1);
        applyStimulus(0, 0, 0, 1);
        waitResult("t3empty", 4'b0000, 0, 1);

        $display("[TB] fourteen accesses overflow the buffer");
        for (int i = 0; i < 13; i++) applyStimulus(1, 32'h3000 + 4 * i, 0, 0);
        applyStimulus(1, 32'h1000, 0, 0);
        checkOutput("t4_overflow_lit", overflow_o, 1);
        applyStimulus(0, 0, 0, 1);
        waitResult("t4", 4'b0000, 0, 14);

        $display("[TB] range matches");
        setTrig(2, 32'h2000_0181, 32'h0000_8000);
        applyStimulus(1, 32'h7FFC, 0, 1);
        waitResult("t5below", 4'b0100, 0, 2);
        applyStimulus(1, 32'h8000, 0, 1);
        waitResult("t5edge", 4'b0000, 0, 2);
        applyStimulus(1, 32'h7000, 1, 1);
        waitResult("t5store", 4'b0000, 0, 2);
        setTrig(3, 32'h2000_0101, 32'h0000_9000);
        applyStimulus(1, 32'h9000, 0, 1);
        waitResult("t5ge", 4'b1000, 0, 2);
        setTrig(3, 32'h2000_0081, 32'h0000_9000);
        applyStimulus(1, 32'h9000, 0, 1);
        waitResult("t5code1", 4'b0000, 0, 2);
        setTrig(3, 32'h0, 32'h0);
        applyStimulus(1, 32'h1000, 0, 1);
        waitResult("t5multi", 4'b0101, 0, 2);

        $display("[TB] retire during a scan");
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'hA000 + 4 * i, 0, 0);
        applyStimulus(1, 32'hA014, 0, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 32'h1000, 0, 1);
        checkOutput("t6_overrun_lit", overrun_o, 1);
        waitResult("t6", 4'b0101, 0, 2);

        $display("[TB] reset in the middle of a scan");
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'hA000 + 4 * i, 0, 0);
        applyStimulus(1, 32'hA014, 0, 1);
        applyStimulus(0, 0, 0, 0);
        rst_i = 1'b1;
        applyStimulus(0, 0, 0, 0);
        rst_i = 1'b0;
        checkOutput("t7_busy_lit", busy_o, 0);
        checkOutput("t7_flags_lit", {overflow_o, overrun_o}, 0);
        repeat (8) applyStimulus(0, 0, 0, 0);

        $display("[TB] privilege qualifier masks trigger0");
        mode_ok_i = 4'b1110;
        applyStimulus(1, 32'h1000, 0, 1);
        waitResult("t8", 4'b0100, 0, 2);
        mode_ok_i = 4'b1111;

        repeat (3) applyStimulus(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
